// File: rtl/dmem_loader_pkg.sv
// Shared types and constants for the data-memory stream loader.
package dmem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StKick,
    StRun,
    StDumpAddr,
    StDumpOut,
    StDone
  } state_e;

  // Encoding of the top-level data-memory port mux.
  localparam logic [1:0] SEL_CORE = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_DUMP = 2'd2;

endpackage

// File: rtl/edge_detect_rise.sv
// One-register rising-edge detector; rise_o is high in the first cycle d_i is seen high.
module edge_detect_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/dmem_stream_loader.sv
// Streams words into data memory, kicks the core, waits for its END edge, then
// reads the result window back out as a valid/ready stream.
module dmem_stream_loader
  import dmem_loader_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned LOAD_WORDS = 1000,
  parameter int unsigned DUMP_BASE  = 0,
  parameter int unsigned DUMP_WORDS = 997,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              go,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        addr_mux_select,
  output logic              core_start,
  input  logic              core_end,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  // One spare bit so a full 2^ADDR_W word count does not wrap.
  localparam int unsigned        CntW     = ADDR_W + 1;
  localparam logic [CntW-1:0]    LoadLast = CntW'(LOAD_WORDS);
  localparam logic [CntW-1:0]    DumpLast = CntW'(DUMP_WORDS);
  localparam logic [ADDR_W-1:0]  DumpBase = ADDR_W'(DUMP_BASE);
  localparam logic [1:0]         LatLast  = 2'(MEM_RD_LAT - 1);

  state_e            state_q;
  logic [CntW-1:0]   ld_cnt_q, dmp_cnt_q;
  logic [1:0]        lat_cnt_q;
  logic              in_ready_q, mem_we_q, start_q, out_valid_q, busy_q, done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, out_data_q;
  logic [1:0]        sel_q;

  logic              end_rise;
  logic              in_xfer;
  logic [CntW-1:0]   ld_cnt_inc, dmp_cnt_inc;

  edge_detect_rise u_end_edge (
    .clk_i  (clk),
    .rst_ni (RESET),
    .d_i    (core_end),
    .rise_o (end_rise)
  );

  assign in_xfer     = in_valid & in_ready_q;
  assign ld_cnt_inc  = ld_cnt_q + CntW'(1);
  assign dmp_cnt_inc = dmp_cnt_q + CntW'(1);

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      ld_cnt_q    <= '0;
      dmp_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_data_q  <= '0;
      sel_q       <= SEL_CORE;
    end else begin
      mem_we_q <= 1'b0;
      start_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (go) begin
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            ld_cnt_q  <= '0;
            dmp_cnt_q <= '0;
            if (LOAD_WORDS == 0) begin
              state_q <= StKick;
              start_q <= 1'b1;
            end else begin
              state_q    <= StLoad;
              sel_q      <= SEL_LOAD;
              in_ready_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (in_xfer) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ld_cnt_q[ADDR_W-1:0];
            mem_wdata_q <= in_data;
            ld_cnt_q    <= ld_cnt_inc;
            in_ready_q  <= (ld_cnt_inc != LoadLast);
          end else if (ld_cnt_q == LoadLast) begin
            // The final write is on the bus this cycle; hand the port back next cycle.
            state_q <= StKick;
            sel_q   <= SEL_CORE;
            start_q <= 1'b1;
          end
        end
        StKick: begin
          state_q <= StRun;
        end
        StRun: begin
          if (end_rise) begin
            if (DUMP_WORDS == 0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StDumpAddr;
              sel_q      <= SEL_DUMP;
              mem_addr_q <= DumpBase;
              lat_cnt_q  <= '0;
            end
          end
        end
        StDumpAddr: begin
          if (lat_cnt_q == LatLast) begin
            state_q <= StDumpOut;
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        StDumpOut: begin
          if (!out_valid_q) begin
            out_data_q  <= mem_rdata;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            dmp_cnt_q   <= dmp_cnt_inc;
            if (dmp_cnt_inc == DumpLast) begin
              // Completion passes straight through to idle with done latched.
              state_q <= StIdle;
              sel_q   <= SEL_CORE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StDumpAddr;
              lat_cnt_q  <= '0;
              mem_addr_q <= DumpBase + dmp_cnt_inc[ADDR_W-1:0];
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          sel_q   <= SEL_CORE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_we          = mem_we_q;
  assign addr_mux_select = sel_q;
  assign core_start      = start_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_dmem_stream_loader.sv
// Bench for dmem_stream_loader: random words and memory contents against a
// behavioural model of the load/kick/run/dump sequence.
module tb_dmem_stream_loader;
  import dmem_loader_pkg::*;

  localparam int unsigned LW  = 4;
  localparam int unsigned DB  = 200;
  localparam int unsigned DN  = 3;
  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic        go = 1'b0, in_valid = 1'b0, core_end = 1'b0, out_ready = 1'b0;
  logic        in_ready, mem_we, core_start, out_valid, busy, done;
  logic [15:0] in_data = '0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, out_data;
  logic [1:0]  addr_mux_select;

  always #5 clk = ~clk;

  dmem_stream_loader #(
    .DATA_W     (16),
    .ADDR_W     (16),
    .LOAD_WORDS (LW),
    .DUMP_BASE  (DB),
    .DUMP_WORDS (DN),
    .MEM_RD_LAT (LAT)
  ) dut (
    .clk             (clk),
    .RESET           (RESET),
    .go              (go),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .mem_rdata       (mem_rdata),
    .addr_mux_select (addr_mux_select),
    .core_start      (core_start),
    .core_end        (core_end),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .busy            (busy),
    .done            (done)
  );

  // Data memory with a LAT-cycle read pipeline.
  logic [15:0] mem [65536];
  logic [15:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: write log, core_start pulses, port-select violations.
  int wr_addr_q[$], wr_data_q[$], wr_cyc_q[$];
  int cs_cnt = 0, cs_cyc = 0, sel_viol = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(int'(mem_wdata));
      wr_cyc_q.push_back(cyc);
      if (addr_mux_select != SEL_LOAD) sel_viol++;
    end
    if (in_ready && addr_mux_select != SEL_LOAD) sel_viol++;
    if (core_start) begin
      cs_cnt++;
      cs_cyc = cyc;
    end
  end

  int          n_checks = 0, n_fail = 0;
  logic [15:0] ld_words [LW];
  logic [15:0] exp_dump [DN];
  logic [15:0] got_q[$];
  logic        done_at_go;

  task automatic rand_words();
    for (int i = 0; i < LW; i++) ld_words[i] = 16'($urandom);
    for (int i = 0; i < DN; i++) begin
      exp_dump[i] = 16'($urandom);
      mem[DB+i]   = exp_dump[i];
    end
  endtask

  task automatic drive_load(input bit gappy, input int stop_after);
    int i = 0, guard = 0;
    bit ph = 1'b0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0; done_at_go = done;
    while (i < stop_after && guard < 100) begin
      ph       = ~ph;
      in_valid = !gappy || ph;
      in_data  = in_valid ? ld_words[i] : 16'($urandom);
      if (in_valid && in_ready) i++;
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (i < stop_after) begin
      n_fail++;
      $display("FAIL load_timeout: accepted %0d words, required %0d", i, stop_after);
    end
  endtask

  task automatic drive_core(input bit go_in_run, output bit early, output bit on_edge);
    int guard = 0;
    early = 1'b0;
    while (core_start !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (core_start !== 1'b1) begin
      n_fail++;
      $display("FAIL start_timeout: core_start=%b after %0d cycles, required 1", core_start, guard);
    end
    // core_end falls 3 cycles after the kick and rises 5 cycles after that.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (addr_mux_select == SEL_DUMP) early = 1'b1;
      if (k == 3) core_end = 1'b0;
      go = go_in_run && (k == 2 || k == 5);
      if (k == 8) core_end = 1'b1;
    end
    @(negedge clk);
    on_edge = (addr_mux_select == SEL_DUMP);
  endtask

  task automatic drain(input int stall, output int unstable);
    int k = 0, st = 0, guard = 0;
    logic [15:0] held = '0;
    unstable = 0;
    while (k < DN && guard < 400) begin
      @(negedge clk);
      guard++;
      out_ready = 1'b0;
      if (out_valid) begin
        if (st == 0) begin
          got_q.push_back(out_data);
          held = out_data;
        end else if (out_data !== held) begin
          unstable++;
        end
        if (st >= stall) begin
          out_ready = 1'b1;
          k++;
          st = 0;
        end else begin
          st++;
        end
      end else if (st != 0) begin
        unstable++;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    n_checks++;
    if (k < DN) begin
      n_fail++;
      $display("FAIL drain_timeout: received %0d words, required %0d", k, DN);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, mem_we, core_start, out_valid, busy, done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000000",
               {in_ready, mem_we, core_start, out_valid, busy, done});
    end
    n_checks++;
    if (addr_mux_select !== SEL_CORE) begin
      n_fail++;
      $display("FAIL reset_sel: got %0d, required 0", addr_mux_select);
    end
    n_checks++;
    if ({mem_addr, mem_wdata, out_data} !== 48'b0) begin
      n_fail++;
      $display("FAIL reset_buses: addr=%0d wdata=%0d out=%0d, required 0", mem_addr, mem_wdata,
               out_data);
    end
    RESET = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b in_ready=%b, required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_full_rate();
    int  wb = wr_addr_q.size(), cb = cs_cnt, gb = got_q.size(), unst, n;
    bit  early, on_edge;
    ld_words[0] = 16'd10; ld_words[1] = 16'd20; ld_words[2] = 16'd30; ld_words[3] = 16'd40;
    exp_dump[0] = 16'd7;  exp_dump[1] = 16'd8;  exp_dump[2] = 16'd9;
    for (int i = 0; i < DN; i++) mem[DB+i] = exp_dump[i];
    core_end = 1'b0;
    drive_load(1'b0, LW);
    drive_core(1'b0, early, on_edge);
    drain(0, unst);
    n = wr_addr_q.size() - wb;
    n_checks++;
    if (n != LW) begin
      n_fail++;
      $display("FAIL full_write_count: got %0d, required %0d", n, LW);
    end
    for (int i = 0; i < LW && i < n; i++) begin
      n_checks++;
      if (wr_addr_q[wb+i] != i || wr_data_q[wb+i] != int'(ld_words[i]) ||
          wr_cyc_q[wb+i] != wr_cyc_q[wb] + i) begin
        n_fail++;
        $display("FAIL full_write%0d: addr=%0d data=%0d cyc+%0d, required addr=%0d data=%0d cyc+%0d",
                 i, wr_addr_q[wb+i], wr_data_q[wb+i], wr_cyc_q[wb+i] - wr_cyc_q[wb], i,
                 ld_words[i], i);
      end
    end
    n_checks++;
    if (cs_cnt - cb != 1 || (n > 0 && cs_cyc != wr_cyc_q[wb+n-1] + 1)) begin
      n_fail++;
      $display("FAIL full_kick: %0d pulses at cycle %0d, required 1 pulse one cycle after last write",
               cs_cnt - cb, cs_cyc);
    end
    n_checks++;
    if (early || !on_edge) begin
      n_fail++;
      $display("FAIL full_dump_start: early=%b on_edge=%b, required 0 1", early, on_edge);
    end
    for (int i = 0; i < DN; i++) begin
      n_checks++;
      if (gb + i >= got_q.size() || got_q[gb+i] !== exp_dump[i]) begin
        n_fail++;
        $display("FAIL full_out%0d: got %0d, required %0d", i,
                 (gb + i < got_q.size()) ? got_q[gb+i] : 16'hxxxx, exp_dump[i]);
      end
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_done: done=%b busy=%b, required 1 0", done, busy);
    end
  endtask

  task automatic test_gappy_load();
    int  wb = wr_addr_q.size(), gb = got_q.size(), unst, n;
    bit  early, on_edge;
    rand_words();
    core_end = 1'b0;
    drive_load(1'b1, LW);
    n_checks++;
    if (done_at_go !== 1'b0) begin
      n_fail++;
      $display("FAIL gappy_done_clear: done=%b after go, required 0", done_at_go);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL gappy_ready_after_last: in_ready=%b, required 0", in_ready);
    end
    // A fifth word stays on offer for the rest of the sequence.
    in_valid = 1'b1;
    in_data  = 16'hbeef;
    drive_core(1'b0, early, on_edge);
    drain(0, unst);
    in_valid = 1'b0;
    n = wr_addr_q.size() - wb;
    n_checks++;
    if (n != LW) begin
      n_fail++;
      $display("FAIL gappy_write_count: got %0d, required %0d", n, LW);
    end
    for (int i = 0; i < LW && i < n; i++) begin
      n_checks++;
      if (wr_addr_q[wb+i] != i || wr_data_q[wb+i] != int'(ld_words[i])) begin
        n_fail++;
        $display("FAIL gappy_write%0d: addr=%0d data=%0d, required addr=%0d data=%0d", i,
                 wr_addr_q[wb+i], wr_data_q[wb+i], i, ld_words[i]);
      end
    end
    for (int i = 0; i < DN; i++) begin
      n_checks++;
      if (gb + i >= got_q.size() || got_q[gb+i] !== exp_dump[i]) begin
        n_fail++;
        $display("FAIL gappy_out%0d: got %0d, required %0d", i,
                 (gb + i < got_q.size()) ? got_q[gb+i] : 16'hxxxx, exp_dump[i]);
      end
    end
  endtask

  task automatic test_core_end_high();
    int  gb = got_q.size(), unst;
    bit  early, on_edge;
    rand_words();
    core_end = 1'b1;
    drive_load(1'b0, LW);
    drive_core(1'b0, early, on_edge);
    n_checks++;
    if (early || !on_edge) begin
      n_fail++;
      $display("FAIL high_end_dump_start: early=%b on_edge=%b, required 0 1", early, on_edge);
    end
    drain(4, unst);
    n_checks++;
    if (unst != 0) begin
      n_fail++;
      $display("FAIL stall_stable: %0d unstable cycles, required 0", unst);
    end
    for (int i = 0; i < DN; i++) begin
      n_checks++;
      if (gb + i >= got_q.size() || got_q[gb+i] !== exp_dump[i]) begin
        n_fail++;
        $display("FAIL stall_out%0d: got %0d, required %0d", i,
                 (gb + i < got_q.size()) ? got_q[gb+i] : 16'hxxxx, exp_dump[i]);
      end
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_done: done=%b busy=%b, required 1 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int  cb = cs_cnt, unst;
    bit  early, on_edge;
    for (int r = 0; r < 2; r++) begin
      int gb = got_q.size();
      rand_words();
      core_end = 1'b0;
      drive_load(1'b0, LW);
      drive_core(1'b0, early, on_edge);
      drain(0, unst);
      for (int i = 0; i < DN; i++) begin
        n_checks++;
        if (gb + i >= got_q.size() || got_q[gb+i] !== exp_dump[i]) begin
          n_fail++;
          $display("FAIL b2b%0d_out%0d: got %0d, required %0d", r, i,
                   (gb + i < got_q.size()) ? got_q[gb+i] : 16'hxxxx, exp_dump[i]);
        end
      end
    end
    n_checks++;
    if (cs_cnt - cb != 2) begin
      n_fail++;
      $display("FAIL b2b_kicks: got %0d pulses, required 2", cs_cnt - cb);
    end
  endtask

  task automatic test_reset_mid_load();
    int  wb, cb, gb, unst, n;
    bit  early, on_edge;
    rand_words();
    core_end = 1'b0;
    drive_load(1'b0, 2);
    #2 RESET = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, mem_we, core_start, out_valid, busy, done} !== 6'b0 ||
        addr_mux_select !== SEL_CORE || mem_addr !== 16'd0 || mem_wdata !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset: flags=%b sel=%0d addr=%0d wdata=%0d, required all 0",
               {in_ready, mem_we, core_start, out_valid, busy, done}, addr_mux_select, mem_addr,
               mem_wdata);
    end
    @(negedge clk);
    RESET = 1'b1;
    wb = wr_addr_q.size();
    cb = cs_cnt;
    gb = got_q.size();
    rand_words();
    drive_load(1'b0, LW);
    drive_core(1'b1, early, on_edge);
    drain(0, unst);
    n = wr_addr_q.size() - wb;
    n_checks++;
    if (n != LW || wr_addr_q[wb] != 0 || wr_data_q[wb] != int'(ld_words[0])) begin
      n_fail++;
      $display("FAIL restart_writes: %0d writes, first addr=%0d, required %0d writes from addr 0",
               n, (n > 0) ? wr_addr_q[wb] : -1, LW);
    end
    n_checks++;
    if (cs_cnt - cb != 1) begin
      n_fail++;
      $display("FAIL run_go_ignored: got %0d kicks, required 1", cs_cnt - cb);
    end
    for (int i = 0; i < DN; i++) begin
      n_checks++;
      if (gb + i >= got_q.size() || got_q[gb+i] !== exp_dump[i]) begin
        n_fail++;
        $display("FAIL restart_out%0d: got %0d, required %0d", i,
                 (gb + i < got_q.size()) ? got_q[gb+i] : 16'hxxxx, exp_dump[i]);
      end
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sel_viol != 0) begin
      n_fail++;
      $display("FAIL restart_done: done=%b busy=%b sel_viol=%0d, required 1 0 0", done, busy,
               sel_viol);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_gappy_load();
    test_core_end_high();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
